// File: rtl/enigma_pkg.sv
// Shared types and constant tables for the Enigma stream core: FSM states,
// table selectors, the 8-entry group shuffles and the rotor B scatter map.
package enigma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [1:0] TBL_PB   = 2'd0;
    localparam logic [1:0] TBL_A    = 2'd1;
    localparam logic [1:0] TBL_B    = 2'd2;
    localparam logic [1:0] TBL_NONE = 2'd3;

    // Row 0 is the identity so that mode 0 leaves each group of 8 in place.
    localparam logic [2:0] SBOX8 [8][8] = '{
        '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
        '{3'd1, 3'd0, 3'd3, 3'd2, 3'd5, 3'd4, 3'd7, 3'd6},
        '{3'd2, 3'd3, 3'd0, 3'd1, 3'd6, 3'd7, 3'd4, 3'd5},
        '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
        '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3},
        '{3'd3, 3'd7, 3'd1, 3'd5, 3'd0, 3'd4, 3'd2, 3'd6},
        '{3'd6, 3'd2, 3'd7, 3'd3, 3'd1, 3'd5, 3'd0, 3'd4},
        '{3'd5, 3'd0, 3'd6, 3'd1, 3'd7, 3'd2, 3'd4, 3'd3}
    };

    // 64-entry team table (odd-multiplier affine map) for 6-bit symbols,
    // bit-reversal of the index for any other width.
    function automatic int sboxb(input int sym_w, input int idx);
        int rev;
        if (sym_w == 6) begin
            return (idx * 37 + 11) % 64;
        end
        rev = 0;
        for (int k = 0; k < sym_w; k++) begin
            if (((idx >> k) & 1) != 0) begin
                rev = rev | (1 << (sym_w - 1 - k));
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/enigma_inv_lookup.sv
// Inverse table lookup: returns the index j with table[j] == value,
// highest matching index wins, 0 when the value is absent.
module enigma_inv_lookup #(
    parameter int SYM_W = 6
) (
    input  logic [SYM_W-1:0] i_table [2**SYM_W],
    input  logic [SYM_W-1:0] i_value,
    output logic [SYM_W-1:0] o_index
);

    localparam int DEPTH = 2 ** SYM_W;

    always_comb begin
        // NOTE: the default assignment before the loop keeps this purely
        // combinational; the ascending scan lets the last (highest) match win.
        o_index = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (i_table[j] == i_value) begin
                o_index = SYM_W'(j);
            end
        end
    end

endmodule

// File: rtl/enigma_stream_core.sv
// Enigma crypt engine: plugboard, stepping rotor A, S-box rotor B and fixed
// reflector, with valid/ready streaming, table loading and rekey.
module enigma_stream_core
    import enigma_pkg::*;
#(
    parameter int SYM_W    = 6,
    parameter int A_STEP_W = 2
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             load,
    input  logic [1:0]       table_idx,
    input  logic             crypt_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] code_in,
    output logic [SYM_W-1:0] code_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int DEPTH = 2 ** SYM_W;
    typedef logic [SYM_W-1:0] sym_t;

    state_t r_state;
    state_t w_state_next;

    sym_t r_addr;
    sym_t r_code_out;
    logic r_out_valid;

    sym_t r_pb [DEPTH];
    sym_t r_a  [DEPTH];
    sym_t r_b  [DEPTH];

    sym_t w_a_next  [DEPTH];
    sym_t w_b_stage [DEPTH];
    sym_t w_b_next  [DEPTH];

    sym_t w_p, w_a, w_b, w_r, w_bb, w_ab, w_y;
    logic [A_STEP_W-1:0] w_ma;
    logic [2:0]          w_mb;

    logic w_accept;
    logic w_load_wr;
    logic w_crypt_acc;
    logic w_enter_load;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Rekey waits for the output register to drain so no result is lost.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (load)                 w_state_next = ST_LOAD;
            ST_LOAD:  if (!load)                w_state_next = ST_READY;
            ST_READY: if (load && !r_out_valid) w_state_next = ST_LOAD;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            ST_LOAD:  in_ready = 1'b1;
            ST_READY: in_ready = !load && (!r_out_valid || out_ready);
            default:  in_ready = 1'b0;
        endcase
    end

    assign w_accept     = in_valid && in_ready;
    assign w_load_wr    = w_accept && (r_state == ST_LOAD);
    assign w_crypt_acc  = w_accept && (r_state == ST_READY);
    assign w_enter_load = (r_state != ST_LOAD) && (w_state_next == ST_LOAD);

    assign w_p = r_pb[code_in];
    assign w_a = r_a[w_p];
    assign w_b = r_b[w_a];
    assign w_r = ~w_b;

    enigma_inv_lookup #(.SYM_W(SYM_W)) u_inv_b (
        .i_table (r_b),
        .i_value (w_r),
        .o_index (w_bb)
    );

    enigma_inv_lookup #(.SYM_W(SYM_W)) u_inv_a (
        .i_table (r_a),
        .i_value (w_bb),
        .o_index (w_ab)
    );

    assign w_y  = r_pb[w_ab];
    assign w_ma = crypt_mode ? w_bb[A_STEP_W-1:0] : w_a[A_STEP_W-1:0];
    assign w_mb = crypt_mode ? w_r[2:0] : w_b[2:0];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_step
        localparam sym_t GBASE = sym_t'(gi - (gi % 8));
        localparam int   SRC_B = sboxb(SYM_W, gi);
        assign w_a_next[gi]  = r_a[sym_t'(gi) - sym_t'(w_ma)];
        assign w_b_stage[gi] = r_b[GBASE | sym_t'(SBOX8[w_mb][gi % 8])];
        assign w_b_next[gi]  = w_b_stage[SRC_B];
    end

    // NOTE: the tables are flop arrays, not RAM, so they can and must be
    // reset to identity, and the whole rotor can be permuted in one cycle.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pb[i] <= sym_t'(i);
                r_a[i]  <= sym_t'(i);
                r_b[i]  <= sym_t'(i);
            end
        end else if (w_load_wr) begin
            case (table_idx)
                TBL_PB:  r_pb[r_addr] <= code_in;
                TBL_A:   r_a[r_addr]  <= code_in;
                TBL_B:   r_b[r_addr]  <= code_in;
                default: ;
            endcase
        end else if (w_crypt_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_a[i] <= w_a_next[i];
                r_b[i] <= w_b_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_addr      <= '0;
            r_code_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_enter_load) begin
                r_addr <= '0;
            end else if (w_load_wr) begin
                r_addr <= r_addr + sym_t'(1);
            end
            if (w_crypt_acc) begin
                r_code_out  <= w_y;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign code_out  = r_code_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_enigma_stream_core.sv
// Randomised self-checking bench for enigma_stream_core against a
// table-level reference model of the Enigma rules.
module tb_enigma_stream_core;

    localparam int D     = 64;
    localparam int ASTEP = 2;

    localparam int TB_SBOX8 [8][8] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7},
        '{1, 0, 3, 2, 5, 4, 7, 6},
        '{2, 3, 0, 1, 6, 7, 4, 5},
        '{7, 6, 5, 4, 3, 2, 1, 0},
        '{4, 5, 6, 7, 0, 1, 2, 3},
        '{3, 7, 1, 5, 0, 4, 2, 6},
        '{6, 2, 7, 3, 1, 5, 0, 4},
        '{5, 0, 6, 1, 7, 2, 4, 3}
    };

    logic       clk = 1'b0;
    logic       srst_n, load, crypt_mode, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] table_idx;
    logic [5:0] code_in, code_out;

    logic       srst4_n, load_4, crypt_mode_4, in_valid_4, in_ready_4, out_valid_4, out_ready_4;
    logic [1:0] table_idx_4;
    logic [3:0] code_in_4, code_out_4;

    int n_checks = 0;
    int n_errors = 0;

    int m_pb [D];
    int m_a  [D];
    int m_b  [D];
    int k_pb [D];
    int k_a  [D];
    int k_b  [D];
    int tmp  [D];
    int pt   [200];
    int ct   [200];

    always #5 clk = ~clk;

    enigma_stream_core u_dut (
        .clk(clk), .srst_n(srst_n), .load(load), .table_idx(table_idx),
        .crypt_mode(crypt_mode), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .code_out(code_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    enigma_stream_core #(.SYM_W(4), .A_STEP_W(1)) u_dut4 (
        .clk(clk), .srst_n(srst4_n), .load(load_4), .table_idx(table_idx_4),
        .crypt_mode(crypt_mode_4), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .code_in(code_in_4), .code_out(code_out_4), .out_valid(out_valid_4),
        .out_ready(out_ready_4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tb_sboxb(input int i);
        return (i * 37 + 11) % 64;
    endfunction

    task automatic model_identity();
        for (int i = 0; i < D; i++) begin
            m_pb[i] = i;
            m_a[i]  = i;
            m_b[i]  = i;
        end
    endtask

    task automatic model_from_keys();
        for (int i = 0; i < D; i++) begin
            m_pb[i] = k_pb[i];
            m_a[i]  = k_a[i];
            m_b[i]  = k_b[i];
        end
    endtask

    task automatic model_crypt(input int x, input int mode, output int y);
        int p, a, b, r, bb, ab, ma, mb;
        int na [D];
        int t  [D];
        int nb [D];
        p = m_pb[x];
        a = m_a[p];
        b = m_b[a];
        r = D - 1 - b;
        bb = 0;
        for (int j = 0; j < D; j++) if (m_b[j] == r) bb = j;
        ab = 0;
        for (int j = 0; j < D; j++) if (m_a[j] == bb) ab = j;
        y  = m_pb[ab];
        ma = ((mode != 0) ? bb : a) % (1 << ASTEP);
        mb = ((mode != 0) ? r : b) % 8;
        for (int i = 0; i < D; i++) na[(i + ma) % D] = m_a[i];
        for (int i = 0; i < D; i++) t[i] = m_b[(i / 8) * 8 + TB_SBOX8[mb][i % 8]];
        for (int i = 0; i < D; i++) nb[i] = t[tb_sboxb(i)];
        for (int i = 0; i < D; i++) begin
            m_a[i] = na[i];
            m_b[i] = nb[i];
        end
    endtask

    task automatic shuffle_tmp();
        int j, s;
        for (int i = 0; i < D; i++) tmp[i] = i;
        for (int i = D - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            s = tmp[i];
            tmp[i] = tmp[j];
            tmp[j] = s;
        end
    endtask

    task automatic make_keys();
        for (int i = 0; i < D; i++) k_pb[i] = i;
        shuffle_tmp();
        for (int j = 0; j < 12; j++) begin
            k_pb[tmp[2*j]]   = tmp[2*j+1];
            k_pb[tmp[2*j+1]] = tmp[2*j];
        end
        shuffle_tmp();
        for (int i = 0; i < D; i++) k_a[i] = tmp[i];
        shuffle_tmp();
        for (int i = 0; i < D; i++) k_b[i] = tmp[i];
    endtask

    task automatic do_reset();
        srst_n   = 1'b0;
        load     = 1'b0;
        in_valid = 1'b0;
        tick();
        srst_n = 1'b1;
        tick();
        model_identity();
    endtask

    task automatic enter_load();
        load     = 1'b1;
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        check("enter_load", in_ready, 1);
    endtask

    task automatic leave_load();
        load     = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic write_table(input int idx);
        int v;
        for (int i = 0; i < D; i++) begin
            case (idx)
                0:       v = k_pb[i];
                1:       v = k_a[i];
                default: v = k_b[i];
            endcase
            table_idx = 2'(idx);
            code_in   = 6'(v);
            in_valid  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic crypt(input int x, input int mode, output int got, output int expv);
        code_in    = 6'(x);
        crypt_mode = mode[0];
        in_valid   = 1'b1;
        #1;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        check("accept", in_ready, 1);
        model_crypt(x, mode, expv);
        tick();
        in_valid = 1'b0;
        check("out_valid", out_valid, 1);
        check("code_out", code_out, expv);
        got = int'(code_out);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int got, expv, y1;

        srst_n = 1'b0; load = 1'b0; table_idx = 2'd0; crypt_mode = 1'b0;
        in_valid = 1'b0; code_in = '0; out_ready = 1'b1;
        srst4_n = 1'b0; load_4 = 1'b0; table_idx_4 = 2'd0; crypt_mode_4 = 1'b0;
        in_valid_4 = 1'b0; code_in_4 = '0; out_ready_4 = 1'b1;

        // Reset and identity encrypt
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_code_out", code_out, 0);
        check("rst_in_ready", in_ready, 0);
        srst_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 0);
        model_identity();
        for (int i = 0; i < D; i++) begin
            k_pb[i] = i; k_a[i] = i; k_b[i] = i;
        end
        enter_load();
        check("load_out_valid", out_valid, 0);
        write_table(0); write_table(1); write_table(2);
        leave_load();
        crypt(0, 0, got, expv);
        check("identity_x0", got, 63);
        for (int n = 0; n < 10; n++) crypt(int'($urandom_range(63, 0)), 0, got, expv);

        // Random tables: encrypt, reset, reload, decrypt
        make_keys();
        do_reset();
        enter_load();
        write_table(0); write_table(1); write_table(2);
        leave_load();
        model_from_keys();
        for (int n = 0; n < 200; n++) begin
            pt[n] = int'($urandom_range(63, 0));
            crypt(pt[n], 0, ct[n], expv);
        end
        do_reset();
        enter_load();
        write_table(0); write_table(1); write_table(2);
        leave_load();
        model_from_keys();
        for (int n = 0; n < 200; n++) begin
            crypt(ct[n], 1, got, expv);
            check("roundtrip", got, pt[n]);
        end

        // Output stall and back-to-back flow
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        crypt(int'($urandom_range(63, 0)), 0, got, y1);
        code_in    = 6'($urandom_range(63, 0));
        crypt_mode = 1'b0;
        in_valid   = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_code_out", code_out, y1);
            tick();
        end
        out_ready = 1'b1;
        crypt(int'(code_in), 0, got, expv);
        for (int n = 0; n < 10; n++) crypt(int'($urandom_range(63, 0)), n % 2, got, expv);

        // Rekey with pending output: rewrite rotor A only
        out_ready = 1'b0;
        load      = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) begin
            check("rekey_hold_in_ready", in_ready, 0);
            check("rekey_hold_out_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("rekey_drained", out_valid, 0);
        check("rekey_not_yet_load", in_ready, 0);
        tick();
        check("rekey_in_load", in_ready, 1);
        shuffle_tmp();
        for (int i = 0; i < D; i++) k_a[i] = tmp[i];
        write_table(1);
        leave_load();
        for (int i = 0; i < D; i++) m_a[i] = k_a[i];
        for (int n = 0; n < 30; n++) crypt(int'($urandom_range(63, 0)), n % 2, got, expv);

        // Asynchronous reset mid-stream
        crypt(int'($urandom_range(63, 0)), 0, got, expv);
        #2;
        srst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_code_out", code_out, 0);
        check("arst_in_ready", in_ready, 0);
        srst_n = 1'b1;
        model_identity();
        tick();
        enter_load();
        leave_load();
        crypt(0, 0, got, expv);
        check("resume_x0", got, 63);
        for (int n = 0; n < 20; n++) crypt(int'($urandom_range(63, 0)), n % 2, got, expv);

        // 4-bit instance: identity crypt, address wrap, ignored table slot
        srst4_n = 1'b1;
        tick();
        check("w4_rst_out_valid", out_valid_4, 0);
        load_4 = 1'b1;
        tick();
        check("w4_load_ready", in_ready_4, 1);
        load_4 = 1'b0;
        tick();
        code_in_4 = 4'd5; crypt_mode_4 = 1'b0; in_valid_4 = 1'b1;
        #1;
        check("w4_accept", in_ready_4, 1);
        tick();
        in_valid_4 = 1'b0;
        check("w4_out_valid", out_valid_4, 1);
        check("w4_identity_x5", code_out_4, 10);
        srst4_n = 1'b0;
        tick();
        srst4_n = 1'b1;
        load_4  = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            table_idx_4 = 2'd3;
            code_in_4   = 4'($urandom_range(15, 0));
            in_valid_4  = 1'b1;
            tick();
        end
        table_idx_4 = 2'd0;
        code_in_4   = 4'd1;
        tick();
        code_in_4 = 4'd0;
        tick();
        in_valid_4 = 1'b0;
        load_4     = 1'b0;
        tick();
        code_in_4  = 4'd0;
        in_valid_4 = 1'b1;
        #1;
        check("w4_accept2", in_ready_4, 1);
        tick();
        in_valid_4 = 1'b0;
        check("w4_wrap_x0", code_out_4, 14);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
